// File: rtl/pipeline_run_control.sv
// ---------------------------------------------------------------------------
// PipelineRunControl (module pipeline_run_control)
//
// Purpose:
//   Run/step/pause/clear sequencer for a 5-stage pipeline. A host/debug port
//   issues commands; the block decides on which cycles the PC and the four
//   pipeline latches advance. When a HALT instruction word appears at IF the
//   pipeline drains the older instructions (PC frozen, bubbles injected into
//   IF/ID) and then parks until a CLEAR is received. A free-running count of
//   enabled cycles is kept for the debug unit.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   synchronous, active-low reset
//   cmd_valid           in   command strobe
//   cmd_code[1:0]       in   0=RUN, 1=STEP, 2=PAUSE, 3=CLEAR
//   cmd_ready           out  command accepted when cmd_valid && cmd_ready
//   fetched_instruction in   instruction word at the IF output this cycle
//   pipe_enable         out  clock-enable for PC and all pipeline latches
//   pipe_flush          out  one-cycle synchronous clear of latches and PC
//   pc_hold             out  PC keeps its value even while pipe_enable=1
//   if_bubble           out  IF/ID captures a zero instruction
//   halted              out  pipeline parked after a HALT word
//   run_state[2:0]      out  current state encoding (debug)
//   cycle_count[B-1:0]  out  enabled cycles since last reset or CLEAR
// ---------------------------------------------------------------------------
module pipeline_run_control #(
    parameter int unsigned    B           = 32,
    parameter logic [B-1:0]   HALT_WORD   = {B{1'b1}},
    parameter int unsigned    DRAIN_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_code,
    output logic         cmd_ready,
    input  logic [B-1:0] fetched_instruction,
    output logic         pipe_enable,
    output logic         pipe_flush,
    output logic         pc_hold,
    output logic         if_bubble,
    output logic         halted,
    output logic [2:0]   run_state,
    output logic [B-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_FLUSH  = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     drainCnt_q, drainCnt_d;
    logic [B-1:0]   cycleCount_q, cycleCount_d;

    logic cmdAccept;
    logic cmdRun;
    logic cmdStep;
    logic cmdPause;
    logic cmdClear;
    logic haltAtIf;

    // Moore outputs decoded straight from the registered state.
    assign cmd_ready   = (state_q != S_FLUSH);
    assign pipe_enable = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    assign pc_hold     = (state_q == S_DRAIN);
    assign if_bubble   = (state_q == S_DRAIN);
    assign halted      = (state_q == S_HALTED);
    assign pipe_flush  = (state_q == S_FLUSH);
    assign run_state   = state_q;
    assign cycle_count = cycleCount_q;

    assign cmdAccept = cmd_valid && cmd_ready;
    assign cmdRun    = cmdAccept && (cmd_code == 2'd0);
    assign cmdStep   = cmdAccept && (cmd_code == 2'd1);
    assign cmdPause  = cmdAccept && (cmd_code == 2'd2);
    assign cmdClear  = cmdAccept && (cmd_code == 2'd3);
    assign haltAtIf  = (fetched_instruction == HALT_WORD);

    // Next-state logic. Within each state the if-chain follows the command
    // priority: CLEAR, then halt detection, then PAUSE, then RUN/STEP.
    // Commands that have no meaning in the current state fall through and
    // are simply dropped (they are still accepted, cmd_ready stays high).
    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmdClear)      state_d = S_FLUSH;
                else if (cmdRun)   state_d = S_RUN;
                else if (cmdStep)  state_d = S_STEP;
            end
            S_RUN: begin
                if (cmdClear) begin
                    state_d = S_FLUSH;
                end else if (haltAtIf) begin
                    state_d    = S_DRAIN;
                    drainCnt_d = 4'(DRAIN_DEPTH - 1);
                end else if (cmdPause) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                // A single enabled cycle; a HALT fetched during it still
                // has to drain, and RUN turns the step into free running.
                if (cmdClear) begin
                    state_d = S_FLUSH;
                end else if (haltAtIf) begin
                    state_d    = S_DRAIN;
                    drainCnt_d = 4'(DRAIN_DEPTH - 1);
                end else if (cmdRun) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cmdClear) begin
                    state_d = S_FLUSH;
                end else if (drainCnt_q == 4'd0) begin
                    state_d = S_HALTED;
                end else begin
                    drainCnt_d = drainCnt_q - 4'd1;
                end
            end
            S_HALTED: begin
                if (cmdClear) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d    = S_IDLE;
                drainCnt_d = 4'd0;
            end
            default: begin
                state_d    = S_IDLE;
                drainCnt_d = 4'd0;
            end
        endcase
    end

    // Enabled-cycle counter. It reads zero from the FLUSH cycle onward, so a
    // CLEAR also discards the cycle on which it was accepted.
    always_comb begin
        cycleCount_d = cycleCount_q;
        if ((state_q == S_FLUSH) || (state_d == S_FLUSH)) begin
            cycleCount_d = '0;
        end else if (pipe_enable) begin
            cycleCount_d = cycleCount_q + {{(B-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            drainCnt_q   <= 4'd0;
            cycleCount_q <= '0;
        end else begin
            state_q      <= state_d;
            drainCnt_q   <= drainCnt_d;
            cycleCount_q <= cycleCount_d;
        end
    end

endmodule
